// File: rtl/tempo_step_sequencer.sv
// Playback scheduler: turns a tempo period (cycles per step) into a one-cycle
// beat strobe and a step index, with start / pause-resume / stop and loop or one-shot modes.
`timescale 1ns/1ps

module tempo_step_sequencer #(
    parameter int STEPS      = 8,
    parameter int PERIOD_W   = 28,
    parameter int MIN_PERIOD = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      pause,
    input  logic                      stop,
    input  logic                      loop_en,
    input  logic [PERIOD_W-1:0]       period_in,
    output logic [$clog2(STEPS)-1:0]  step,
    output logic                      beat,
    output logic                      running,
    output logic                      paused,
    output logic                      done,
    output logic [PERIOD_W-1:0]       period_active
);

    localparam int STEP_W = $clog2(STEPS);
    localparam logic [STEP_W-1:0]   LAST_STEP = STEP_W'(STEPS - 1);
    localparam logic [PERIOD_W-1:0] MIN_P     = PERIOD_W'(MIN_PERIOD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t              state;
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] p_clamped;

    assign p_clamped = (period_in < MIN_P) ? MIN_P : period_in;

    // NOTE: every register here uses <= so all of them update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            step          <= '0;
            beat          <= 1'b0;
            running       <= 1'b0;
            paused        <= 1'b0;
            done          <= 1'b0;
            period_active <= MIN_P;
            cnt           <= '0;
        end else begin
            // Strobes default low; only the branches below raise them for a single cycle.
            beat <= 1'b0;
            done <= 1'b0;

            if (stop) begin
                state   <= IDLE;
                step    <= '0;
                cnt     <= '0;
                running <= 1'b0;
                paused  <= 1'b0;
            end else if (start) begin
                state         <= RUN;
                step          <= '0;
                beat          <= 1'b1;
                cnt           <= p_clamped - 1'b1;
                period_active <= p_clamped;
                running       <= 1'b1;
                paused        <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    RUN: begin
                        if (pause) begin
                            // Pause wins over a boundary in the same cycle; the boundary is simply deferred.
                            state  <= PAUSE;
                            paused <= 1'b1;
                        end else if (cnt == '0) begin
                            if (step != LAST_STEP || loop_en) begin
                                step          <= (step == LAST_STEP) ? '0 : step + 1'b1;
                                beat          <= 1'b1;
                                cnt           <= p_clamped - 1'b1;
                                period_active <= p_clamped;
                            end else begin
                                state   <= IDLE;
                                step    <= '0;
                                done    <= 1'b1;
                                running <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    PAUSE: begin
                        if (pause) begin
                            state  <= RUN;
                            paused <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                        paused  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tempo_step_sequencer.sv
// Directed bench for tempo_step_sequencer (STEPS=4): beat timing, tempo change,
// pause/resume, clamping, stop/start priority and reset, against hand-derived values.
`timescale 1ns/1ps

module tb_tempo_step_sequencer;

    localparam int STEPS    = 4;
    localparam int PERIOD_W = 28;

    logic                clk = 1'b0;
    logic                reset, start, pause, stop, loop_en;
    logic [PERIOD_W-1:0] period_in;
    logic [1:0]          step;
    logic                beat, running, paused, done;
    logic [PERIOD_W-1:0] period_active;

    int total = 0;
    int bad   = 0;
    int cyc;

    tempo_step_sequencer #(.STEPS(STEPS), .PERIOD_W(PERIOD_W), .MIN_PERIOD(2)) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .stop(stop),
        .loop_en(loop_en), .period_in(period_in), .step(step), .beat(beat),
        .running(running), .paused(paused), .done(done), .period_active(period_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @cyc%0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Inputs set before tick() are sampled on its edge; outputs read after belong to the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic st, input logic sp, input logic ps);
        start = st; stop = sp; pause = ps;
        tick();
        start = 0; stop = 0; pause = 0;
    endtask

    task automatic do_reset();
        reset = 1; start = 0; stop = 0; pause = 0;
        tick();
        reset = 0;
        cyc = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_step"},    32'(step), 0);
        check({tag, "_beat"},    32'(beat), 0);
        check({tag, "_running"}, 32'(running), 0);
        check({tag, "_paused"},  32'(paused), 0);
        check({tag, "_done"},    32'(done), 0);
        check({tag, "_period"},  32'(period_active), 2);
    endtask

    initial begin
        reset = 1; start = 0; pause = 0; stop = 0; loop_en = 0; period_in = 5;
        cyc = 0;
        tick(); tick();
        reset = 0;
        check_reset_vals("rst");

        // One-shot: beats at 1,6,11,16, done at 21.
        do_reset();
        loop_en = 0; period_in = 5;
        for (int c = 0; c < 30; c++) begin
            start = (c == 0);
            tick();
            check("os_beat", 32'(beat), 32'((cyc <= 16) && ((cyc - 1) % 5 == 0)));
            check("os_done", 32'(done), 32'(cyc == 21));
            check("os_running", 32'(running), 32'(cyc < 21));
            check("os_step", 32'(step), (cyc < 21) ? 32'((cyc - 1) / 5) : 0);
        end

        // Loop: beats every 5 cycles forever, step wraps, done never.
        do_reset();
        loop_en = 1; period_in = 5;
        for (int c = 0; c < 45; c++) begin
            start = (c == 0);
            tick();
            check("lp_beat", 32'(beat), 32'((cyc - 1) % 5 == 0));
            check("lp_step", 32'(step), 32'(((cyc - 1) / 5) % 4));
            check("lp_done", 32'(done), 0);
            if (cyc == 21) check("lp_period", 32'(period_active), 5);
        end

        // Tempo change 5 -> 3 at cycle 3 takes effect only from the step-1 boundary.
        do_reset();
        loop_en = 1; period_in = 5;
        for (int c = 0; c < 17; c++) begin
            start = (c == 0);
            period_in = (c >= 3) ? 3 : 5;
            tick();
            check("tc_beat", 32'(beat), 32'(cyc == 1 || cyc == 6 || (cyc > 6 && (cyc - 6) % 3 == 0)));
            check("tc_step", 32'(step), (cyc < 6) ? 0 : (cyc < 9) ? 1 : (cyc < 12) ? 2 : (cyc < 15) ? 3 : 0);
            check("tc_period", 32'(period_active), (cyc < 6) ? 5 : 3);
        end

        // Pause at 8, resume at 18: paused 9..18, next beat at 22, none on resume.
        do_reset();
        loop_en = 1; period_in = 5;
        for (int c = 0; c < 23; c++) begin
            start = (c == 0);
            pause = (c == 8 || c == 18);
            tick();
            check("pz_beat", 32'(beat), 32'(cyc == 1 || cyc == 6 || cyc == 22));
            check("pz_paused", 32'(paused), 32'(cyc >= 9 && cyc <= 18));
            check("pz_step", 32'(step), (cyc < 6) ? 0 : (cyc < 22) ? 1 : 2);
            check("pz_running", 32'(running), 1);
        end
        pause = 0;

        // period_in=0 clamps to 2; stop at cycle 4 beats the boundary in that cycle.
        do_reset();
        loop_en = 1; period_in = 0;
        for (int c = 0; c < 8; c++) begin
            start = (c == 0);
            stop  = (c == 4);
            tick();
            check("cl_beat", 32'(beat), 32'(cyc <= 4 && (cyc % 2 == 1)));
            check("cl_running", 32'(running), 32'(cyc <= 4));
            check("cl_step", 32'(step), (cyc < 3) ? 0 : (cyc <= 4) ? 1 : 0);
            check("cl_done", 32'(done), 0);
            if (cyc == 1) check("cl_period", 32'(period_active), 2);
        end
        stop = 0;

        // Priority cases.
        do_reset();
        period_in = 5; loop_en = 1;
        drive(0, 0, 1);
        check("idle_pause_paused", 32'(paused), 0);
        check("idle_pause_running", 32'(running), 0);
        drive(1, 1, 0);
        check("ss_idle_running", 32'(running), 0);
        check("ss_idle_beat", 32'(beat), 0);
        drive(1, 0, 0);
        tick();
        drive(1, 1, 0);
        check("ss_run_running", 32'(running), 0);
        check("ss_run_step", 32'(step), 0);
        drive(1, 0, 0);
        drive(0, 0, 1);
        check("pz_enter", 32'(paused), 1);
        drive(1, 0, 1);
        check("start_over_pause_beat", 32'(beat), 1);
        check("start_over_pause_paused", 32'(paused), 0);
        check("start_over_pause_running", 32'(running), 1);

        // Reset mid-step with a non-default period in use.
        period_in = 7;
        drive(1, 0, 0);
        tick(); tick();
        check("mid_period", 32'(period_active), 7);
        reset = 1;
        tick();
        reset = 0;
        check_reset_vals("midrst");
        tick();
        check("midrst_idle_beat", 32'(beat), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tempo_step_sequencer.md
Name: tempo_step_sequencer

Overview:
- Playback scheduler for the composer. Takes the tempo period (cycles per step) from the tempo-select block and converts it into a one-cycle beat strobe and a step index.
- The note/pattern memory and tone generator consume the beat strobe and step index.
- Provides start, pause/resume and stop control, plus loop or one-shot playback.
- A tempo change is applied only at a step boundary, so the current note length never glitches.

Parameters:
- STEPS, 8, number of steps in a pattern (≥2).
- PERIOD_W, 28, width of the tempo period input.
- MIN_PERIOD, 2, smallest legal period; smaller inputs are clamped up to this value.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: begin playback at step 0 (restarts if already playing)
- pause  in  1  one-cycle pulse: toggles between RUN and PAUSE; ignored in IDLE
- stop  in  1  one-cycle pulse: abort to IDLE
- loop_en  in  1  1 = wrap from the last step to step 0; 0 = stop after the last step
- period_in  in  PERIOD_W  requested cycles per step
- step  out  $clog2(STEPS)  current step index
- beat  out  1  one-cycle pulse in the first cycle of each step
- running  out  1  high in RUN and in PAUSE
- paused  out  1  high in PAUSE only
- done  out  1  one-cycle pulse when one-shot playback ends
- period_active  out  PERIOD_W  period in use for the current step

Behaviour:
- All outputs are registered. Every register is cleared on a clk edge with reset=1, regardless of state. Reset values: state=IDLE, step=0, beat=0, running=0, paused=0, done=0, period_active=MIN_PERIOD, internal counter cnt=0.
- Input priority in the same cycle: reset > stop > start > pause.
- Clamp: P = (period_in < MIN_PERIOD) ? MIN_PERIOD : period_in. All comparisons are unsigned.
- Period sampling: P is sampled only on start and at step boundaries. It is latched into period_active.

States:
- IDLE:
  - start → RUN. Next cycle: step=0, beat=1, cnt=P-1, period_active=P.
  - pause is ignored. stop holds IDLE.
- RUN: cnt decrements by 1 each cycle. Boundary when cnt==0 (and no stop, start or pause that cycle):
  - If step<STEPS-1: next cycle step=step+1, beat=1, cnt=P-1, period_active=P.
  - If step==STEPS-1 and loop_en==1: next cycle step=0, beat=1, cnt=P-1, period_active=P.
  - If step==STEPS-1 and loop_en==0: next cycle state=IDLE, step=0, done=1, beat=0.
  - loop_en is sampled at the boundary cycle only.
- RUN with pause sampled: → PAUSE. cnt does not decrement on that edge.
  - If cnt==0 in that same cycle, the boundary is deferred (pause wins).
- PAUSE:
  - cnt, step and period_active are frozen.
  - pause sampled → RUN. cnt does not decrement on that edge, and no beat is issued on resume.
- RUN or PAUSE with start sampled: restart exactly as from IDLE (step=0, beat=1 next cycle, paused=0).
- Any state with stop sampled: next cycle IDLE, step=0, cnt=0. No beat, no done.

Timing and outputs:
- Consecutive beats are spaced exactly period_active cycles apart while in RUN.
- A pause sampled at cycle p and a resume sampled at cycle r delay the next beat by r−p+1 cycles.
- running = (state != IDLE). paused = (state == PAUSE).
- beat and done are never high in the same cycle.
- beat is never high in IDLE or PAUSE.

Test Plan:
- STEPS=4, period_in=5, loop_en=0, start at cycle 0 → beat at cycles 1, 6, 11, 16 with step=0, 1, 2, 3; done=1 at cycle 21 with step=0 and running=0; no further beats.
- STEPS=4, period_in=5, loop_en=1 → beat at cycle 21 with step=0; period_active=5; 20-cycle step pattern repeats; done never asserts.
- Tempo change: period_in switched from 5 to 3 at cycle 3 → step 1 beat still at cycle 6, then beats at 9, 12, 15 (period_active=3 from cycle 6).
- Pause at cycle 8, resume at cycle 18 → paused=1 for cycles 9–18, step frozen at 1, next beat at cycle 22 (11-cycle delay); no beat on resume.
- period_in=0 → clamped: beats every 2 cycles, period_active=2. stop at cycle 4 → cycle 5: IDLE, step=0, no done.
- Priority: start and stop in the same cycle → IDLE. reset asserted mid-step → all outputs at their reset values on the next cycle.
